alu_muldiv_sequencer: RTL and testbench
=======================================

Name: alu_muldiv_sequencer

Overview:
Multi-cycle sequencer that implements unsigned multiply and divide (MUL, MULHU, DIVU, REMU) by driving one shared combinational ALU instance one iteration per clock. It sits beside the ALU in the execute stage. It takes operands on a START pulse and owns the ALU operand/operation lines while busy. It returns a registered result with a one-cycle DONE pulse.

Parameters:
SIZE, 32, datapath width; also the iteration count. Must be a power of two and at least 4.

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
START  input  1  request pulse; sampled only in IDLE
FUNCT  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU
OP_A  input  SIZE  multiplicand / dividend
OP_B  input  SIZE  multiplier / divisor
BUSY  output  1  high in RUN and DONE states
DONE  output  1  one-cycle pulse; RESULT valid
RESULT  output  SIZE  registered result, held until next accepted START
ALU_A  output  SIZE  to ALU input A
ALU_B  output  SIZE  to ALU input B
ALU_OP  output  4  to ALU OPERATION; uses the ADD/SUB codes from operation_type.sv
ALU_RESULT  input  SIZE  from ALU RESULT, same cycle, combinational

Behaviour:
- Reset (synchronous, any state including mid-operation): state=IDLE, BUSY=0, DONE=0, RESULT=0, iteration counter=0, internal registers=0. The operation in flight is discarded and produces no DONE.
- States: IDLE, RUN, DONE.
- IDLE + START: latch FUNCT. Load registers: HI=0, LO=OP_A for divide or OP_B for multiply, M=OP_B for divide or OP_A for multiply. Counter=0. Next state is RUN.
- Divide-by-zero exception: IDLE + START, FUNCT=DIVU/REMU, OP_B=0. Next state is DONE directly. RESULT=all ones for DIVU, OP_A for REMU.
- START outside IDLE is ignored, with no side effects. FUNCT/OP_A/OP_B only matter on the accepting edge.
- IDLE/DONE ALU drive: ALU_OP=ADD, ALU_A=0, ALU_B=0.
- RUN multiply step, one per cycle:
  - Drive ALU_OP=ADD, ALU_A=HI, ALU_B=M.
  - If LO[0]=1: sum=ALU_RESULT, carry c=(sum<M), unsigned compare done locally. Otherwise sum=HI, c=0.
  - Shift {c,sum,LO} right by 1 into {HI,LO}.
- RUN divide step, one per cycle:
  - rs={HI[SIZE-2:0],LO[SIZE-1]}, msb=HI[SIZE-1].
  - Drive ALU_OP=SUB, ALU_A=rs, ALU_B=M.
  - take=msb | (rs>=M), unsigned compare local.
  - HI = take ? ALU_RESULT : rs.
  - LO={LO[SIZE-2:0],take}.
- The counter increments each RUN cycle. On the edge completing step SIZE (counter==SIZE-1):
  - next state is DONE;
  - RESULT=LO for MUL, HI for MULHU, LO (quotient) for DIVU, HI (remainder) for REMU.
- DONE state: DONE=1 for exactly one cycle; next state is IDLE. START is not accepted in DONE.
- Latency: START accepted at edge 0, DONE high in the cycle following edge SIZE (32 cycles at default). Divide-by-zero: DONE high in the cycle following edge 0. Back-to-back issue interval is SIZE+2 cycles.
- All arithmetic is modulo 2^SIZE. No signed operations. RESULT never changes except on DONE entry or reset.

Test Plan:
- MUL 7×6: START with FUNCT=00, A=7, B=6 → DONE 32 cycles after the accept edge, RESULT=42. BUSY is high for 33 cycles.
- MULHU and MUL of 0xFFFFFFFF×0xFFFFFFFF → MULHU RESULT=0xFFFFFFFE. A second run with FUNCT=00 gives RESULT=0x00000001, exercising the carry path.
- DIVU/REMU 100÷7 → 14 / 2. Dividend 0xFFFFFFFF ÷ 0x80000001 → quotient 1, remainder 0x7FFFFFFE, exercising the msb path.
- Divide by zero: A=0x12345678, B=0, DIVU → RESULT=0xFFFFFFFF, DONE one cycle after accept. REMU → 0x12345678. No RUN cycles; ALU_OP stays ADD.
- START pulsed at cycle 10 of a running MUL with different operands → ignored; first result unchanged. The next START after DONE is accepted.
- RESET asserted at cycle 15 of a DIVU → next cycle BUSY=0, RESULT=0, no DONE pulse. A new MUL 3×5 then returns 15 with normal latency.

Source files
------------

// File: rtl/alu_muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the multiply/divide sequencer.
interface alu_muldiv_sequencer_if #(
    parameter int SIZE = 32
) ();
    logic            start;
    logic [1:0]      funct;
    logic [SIZE-1:0] op_a;
    logic [SIZE-1:0] op_b;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] result;

    modport master (
        output start, funct, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, funct, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// Unsigned MUL/MULHU/DIVU/REMU by iterating the shared execute-stage ALU once per clock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; ALU lines parked on ADD 0+0
// RUN     | one shift-add (mul) or restoring-subtract (div) step per cycle
// DONE    | done pulse, result valid; start ignored
module alu_muldiv_sequencer #(
    parameter int         SIZE    = 32,
    parameter logic [3:0] ALU_ADD = 4'b0000,
    parameter logic [3:0] ALU_SUB = 4'b0001
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_muldiv_sequencer_if.slave bus,
    output logic [SIZE-1:0]       alu_a,
    output logic [SIZE-1:0]       alu_b,
    output logic [3:0]            alu_op,
    input  logic [SIZE-1:0]       alu_result
);

    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state;
    logic [1:0]      funct_q;
    logic [SIZE-1:0] hi;
    logic [SIZE-1:0] lo;
    logic [SIZE-1:0] m;
    logic [SIZE-1:0] result_q;
    logic [CW-1:0]   cnt;

    logic [SIZE-1:0] rs;
    logic            take;
    logic [SIZE-1:0] mul_sum;
    logic            mul_c;
    logic [SIZE-1:0] hi_n;
    logic [SIZE-1:0] lo_n;

    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = result_q;

    // funct_q[1] selects divide; funct_q[0] selects the high word / remainder.
    always_comb begin
        rs      = {hi[SIZE-2:0], lo[SIZE-1]};
        take    = hi[SIZE-1] | (rs >= m);
        mul_sum = lo[0] ? alu_result : hi;
        mul_c   = lo[0] & (alu_result < m);
        alu_op  = ALU_ADD;
        alu_a   = '0;
        alu_b   = '0;
        hi_n    = hi;
        lo_n    = lo;
        if (state == ST_RUN) begin
            if (funct_q[1]) begin
                alu_op = ALU_SUB;
                alu_a  = rs;
                alu_b  = m;
                hi_n   = take ? alu_result : rs;
                lo_n   = {lo[SIZE-2:0], take};
            end else begin
                alu_a  = hi;
                alu_b  = m;
                hi_n   = {mul_c, mul_sum[SIZE-1:1]};
                lo_n   = {mul_sum[0], lo[SIZE-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            funct_q  <= '0;
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            result_q <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        funct_q <= bus.funct;
                        hi      <= '0;
                        cnt     <= '0;
                        lo      <= bus.funct[1] ? bus.op_a : bus.op_b;
                        m       <= bus.funct[1] ? bus.op_b : bus.op_a;
                        // Divide by zero short-circuits straight to the result.
                        if (bus.funct[1] && (bus.op_b == '0)) begin
                            result_q <= bus.funct[0] ? bus.op_a : '1;
                            state    <= ST_DONE;
                        end else begin
                            state    <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        result_q <= funct_q[0] ? hi_n : lo_n;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Vector table plus hand sequences for ignored start and mid-operation reset; results checked
// through an expected-result queue popped on each done pulse.
module tb_alu_muldiv_sequencer;

    localparam int         SIZE = 32;
    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b0001;

    typedef struct {
        logic [1:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [3:0]  alu_op;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_result = 32'd0;
    vec_t        vecs[16];

    always #5 clk = ~clk;

    alu_muldiv_sequencer_if #(.SIZE(SIZE)) bus ();

    alu_muldiv_sequencer #(
        .SIZE   (SIZE),
        .ALU_ADD(ADD),
        .ALU_SUB(SUB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_result(alu_result)
    );

    // Reference ALU: only ADD and SUB are ever requested.
    always_comb alu_result = (alu_op == SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) check("spurious_done", {31'b0, bus.done}, 32'd0);
            else check("result", bus.result, sb_q.pop_front());
        end
    end

    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int inject);
        int lat;
        int busy_cnt;
        int guard;
        int exp_lat;
        bit saw_sub;
        bit saw_bad;
        bit div0;
        guard = 0;
        while (bus.busy !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct = f;
        bus.op_a  = a;
        bus.op_b  = b;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.funct = 2'($urandom);
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        lat = 0; busy_cnt = 0; saw_sub = 0; saw_bad = 0;
        while (bus.done !== 1'b1 && lat < 3 * SIZE) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (alu_op == SUB) saw_sub = 1;
            else if (alu_op != ADD) saw_bad = 1;
            if (lat == 5) check("result_held", bus.result, last_result);
            if (lat == inject) begin
                bus.start = 1'b1;
                bus.funct = 2'b10;
                bus.op_a  = $urandom;
                bus.op_b  = 32'd0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        if (bus.busy === 1'b1) busy_cnt++;
        div0    = f[1] && (b == 32'd0);
        exp_lat = div0 ? 0 : SIZE;
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(busy_cnt), 32'(exp_lat + 1));
        check("alu_sub_used", {31'b0, saw_sub}, {31'b0, f[1] && !div0});
        check("alu_op_legal", {31'b0, saw_bad}, 32'd0);
        last_result = exp;
    endtask

    initial begin
        vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[2]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
        vecs[3]  = '{2'b10, 32'd100,        32'd7,          32'd14};
        vecs[4]  = '{2'b11, 32'd100,        32'd7,          32'd2};
        vecs[5]  = '{2'b10, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1};
        vecs[6]  = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE};
        vecs[7]  = '{2'b10, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF};
        vecs[8]  = '{2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678};
        vecs[9]  = '{2'b00, 32'h0001_0000,  32'h0001_0000,  32'd0};
        vecs[10] = '{2'b01, 32'h0001_0000,  32'h0001_0000,  32'd1};
        vecs[11] = '{2'b01, 32'hFFFF_FFFF,  32'd2,          32'd1};
        vecs[12] = '{2'b10, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[13] = '{2'b11, 32'd5,          32'd9,          32'd5};
        vecs[14] = '{2'b10, 32'd5,          32'd9,          32'd0};
        vecs[15] = '{2'b00, 32'd0,          32'hDEAD_BEEF,  32'd0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.funct = 2'b00;
        bus.op_a  = 32'd0;
        bus.op_b  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'b0, bus.busy}, 32'd0);
        check("reset_done",   {31'b0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_alu_op", {28'b0, alu_op}, {28'b0, ADD});
        check("reset_alu_a",  alu_a, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) run_op(vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].exp, -1);

        // start during RUN must be ignored; the following start is accepted normally
        run_op(2'b00, 32'd9, 32'd11, 32'd99, 10);
        run_op(2'b00, 32'd7, 32'd6, 32'd42, -1);

        // reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct = 2'b10;
        bus.op_a  = 32'd1000;
        bus.op_b  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",   {31'b0, bus.busy}, 32'd0);
        check("abort_done",   {31'b0, bus.done}, 32'd0);
        check("abort_result", bus.result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        last_result = 32'd0;
        repeat (40) @(negedge clk);
        check("abort_idle", {31'b0, bus.busy}, 32'd0);
        run_op(2'b00, 32'd3, 32'd5, 32'd15, -1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
